req_encoder_8_3: RTL and testbench

- Sequential 8-to-3 encoder for the traffic monitor. It is the upstream counterpart of the 3-8 decoder.
- It captures asynchronous one-per-lane event lines, queues them as pending requests, and arbitrates among them.
- It presents one 3-bit lane code at a time on a valid/ready handshake, for the controller and the display decoder path.

---
 rtl/req_encoder_8_3.sv | 145 ++++++++++++++
 tb/tb_req_encoder_8_3.sv | 409 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/req_encoder_8_3.sv
// Sequential 8-to-3 request encoder: synchronizes per-lane event lines,
// queues rising edges as pending requests and hands out one lane code at a
// time over a valid/ready handshake.
module req_encoder_8_3 #(
  parameter int unsigned SYNC_STAGES    = 2,
  parameter bit          ROUND_ROBIN    = 1'b1,
  parameter bit          REQ_ACTIVE_LOW = 1'b0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       EN,
  input  logic [7:0] REQ,
  input  logic       READY,
  input  logic       OVF_CLR,
  output logic [2:0] CODE,
  output logic       VALID,
  output logic [7:0] PENDING,
  output logic       OVF,
  output logic [7:0] EVT_CNT
);

  localparam int unsigned LANES = 8;
  localparam int unsigned LW    = 3;

  typedef enum logic {
    IDLE    = 1'b0,
    PRESENT = 1'b1
  } state_t;

  state_t                              state_q;
  logic [LW-1:0]                       ptr_q;
  logic [SYNC_STAGES-1:0][LANES-1:0]   sync_q;
  logic [LANES-1:0]                    hist_q;

  logic [LANES-1:0] req_norm;
  logic [LANES-1:0] evt;
  logic [LANES-1:0] evt_cap;
  logic [LANES-1:0] grant_mask;
  logic [LANES-1:0] held_mask;
  logic [LW-1:0]    sel;
  logic [LW-1:0]    idx;
  logic             found;
  logic             accept;
  logic             grant_fire;
  logic             ovf_evt;

  // Polarity normalization ahead of the synchronizer
  assign req_norm = REQ_ACTIVE_LOW ? ~REQ : REQ;

  // Synchronizer chain plus one history stage for rising-edge detection
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q <= '0;
      hist_q <= '0;
    end else begin
      sync_q[0] <= req_norm;
      for (int unsigned i = 1; i < SYNC_STAGES; i++) begin
        sync_q[i] <= sync_q[i-1];
      end
      hist_q <= sync_q[SYNC_STAGES-1];
    end
  end

  // Pick the next lane to grant from the pending set
  always_comb begin
    sel   = '0;
    idx   = '0;
    found = 1'b0;
    if (ROUND_ROBIN) begin
      // Scan ptr+1 .. ptr+8, wrapping naturally in 3 bits
      for (int unsigned k = 1; k <= LANES; k++) begin
        idx = ptr_q + LW'(k);
        if (!found && PENDING[idx]) begin
          sel   = idx;
          found = 1'b1;
        end
      end
    end else begin
      for (int unsigned k = 0; k < LANES; k++) begin
        if (!found && PENDING[k]) begin
          sel   = LW'(k);
          found = 1'b1;
        end
      end
    end
  end

  // Event qualification, grant decision and overflow detection
  always_comb begin
    evt        = sync_q[SYNC_STAGES-1] & ~hist_q;
    evt_cap    = EN ? evt : '0;
    accept     = VALID & READY;
    grant_fire = EN & (|PENDING) & (~VALID | READY);
    grant_mask = grant_fire ? (LANES'(1) << sel) : '0;
    // Lane still sitting unaccepted in CODE counts as occupied
    held_mask  = (VALID & ~READY) ? (LANES'(1) << CODE) : '0;
    ovf_evt    = |(evt_cap & ((PENDING & ~grant_mask) | held_mask));
  end

  // Handshake FSM with pending queue, overflow flag and handshake counter
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      ptr_q   <= LW'(LANES - 1);
      CODE    <= '0;
      VALID   <= 1'b0;
      PENDING <= '0;
      OVF     <= 1'b0;
      EVT_CNT <= '0;
    end else begin
      // A same-edge event re-sets a bit the grant is clearing
      PENDING <= (PENDING & ~grant_mask) | evt_cap;
      OVF     <= (OVF & ~OVF_CLR) | ovf_evt;
      if (accept) begin
        EVT_CNT <= EVT_CNT + 8'd1;
      end
      case (state_q)
        IDLE: begin
          if (grant_fire) begin
            state_q <= PRESENT;
            VALID   <= 1'b1;
            CODE    <= sel;
            ptr_q   <= sel;
          end
        end
        PRESENT: begin
          if (READY) begin
            if (grant_fire) begin
              CODE  <= sel;
              ptr_q <= sel;
            end else begin
              state_q <= IDLE;
              VALID   <= 1'b0;
            end
          end
        end
        default: begin
          state_q <= IDLE;
          VALID   <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_req_encoder_8_3.sv
// Bench for req_encoder_8_3: a round-robin and a fixed-priority instance
// share stimulus and are checked against a lane-level behavioural model.
module tb_req_encoder_8_3;

  localparam int SYNC = 2;

  logic       clk;
  logic       rst;
  logic       en;
  logic [7:0] req;
  logic       ready;
  logic       ovf_clr;

  logic [2:0] code_r, code_f;
  logic       valid_r, valid_f;
  logic [7:0] pend_r, pend_f;
  logic       ovf_r, ovf_f;
  logic [7:0] cnt_r, cnt_f;

  int checks;
  int errors;

  // model state: index 0 = round robin, 1 = fixed priority
  logic [7:0] dq[$];
  logic [7:0] m_hist;
  int         m_code[2];
  bit         m_valid[2];
  logic [7:0] m_pend[2];
  bit         m_ovf[2];
  int         m_cnt[2];
  int         m_ptr[2];

  req_encoder_8_3 #(.SYNC_STAGES(2), .ROUND_ROBIN(1'b1), .REQ_ACTIVE_LOW(1'b0)) u_rr (
    .clk(clk), .rst(rst), .EN(en), .REQ(req), .READY(ready), .OVF_CLR(ovf_clr),
    .CODE(code_r), .VALID(valid_r), .PENDING(pend_r), .OVF(ovf_r), .EVT_CNT(cnt_r)
  );

  req_encoder_8_3 #(.SYNC_STAGES(2), .ROUND_ROBIN(1'b0), .REQ_ACTIVE_LOW(1'b0)) u_fix (
    .clk(clk), .rst(rst), .EN(en), .REQ(req), .READY(ready), .OVF_CLR(ovf_clr),
    .CODE(code_f), .VALID(valid_f), .PENDING(pend_f), .OVF(ovf_f), .EVT_CNT(cnt_f)
  );

  always #5 clk = ~clk;

  function automatic logic [20:0] dut_vec(int m);
    if (m == 0) return {code_r, valid_r, pend_r, ovf_r, cnt_r};
    return {code_f, valid_f, pend_f, ovf_f, cnt_f};
  endfunction

  function automatic logic [20:0] exp_vec(int m);
    return {3'(m_code[m]), m_valid[m], m_pend[m], m_ovf[m], 8'(m_cnt[m])};
  endfunction

  task automatic model_reset();
    dq.delete();
    for (int i = 0; i < SYNC; i++) dq.push_back(8'h00);
    m_hist = 8'h00;
    for (int m = 0; m < 2; m++) begin
      m_code[m] = 0; m_valid[m] = 0; m_pend[m] = 8'h00;
      m_ovf[m] = 0; m_cnt[m] = 0; m_ptr[m] = 7;
    end
  endtask

  // One clock of lane-level behaviour, from the inputs present at the edge
  task automatic model_step();
    logic [7:0] sync_out, evt;
    bit accept, grant, ovf_new;
    int sel, lane;
    sync_out = dq[$];
    evt = sync_out & ~m_hist;
    m_hist = sync_out;
    dq.push_front(req);
    void'(dq.pop_back());
    for (int m = 0; m < 2; m++) begin
      accept = m_valid[m] && ready;
      grant = en && (m_pend[m] != 8'h00) && (!m_valid[m] || ready);
      sel = -1;
      if (grant) begin
        for (int k = 1; k <= 8; k++) begin
          lane = (m == 0) ? (m_ptr[m] + k) % 8 : k - 1;
          if (sel < 0 && m_pend[m][lane]) sel = lane;
        end
      end
      ovf_new = 0;
      if (en) begin
        for (int l = 0; l < 8; l++) begin
          if (evt[l]) begin
            if (m_pend[m][l] && l != sel) ovf_new = 1;
            if (m_valid[m] && m_code[m] == l && !ready) ovf_new = 1;
          end
        end
      end
      if (accept) m_cnt[m] = (m_cnt[m] + 1) % 256;
      if (grant) begin
        m_pend[m][sel] = 1'b0;
        m_code[m] = sel;
        m_ptr[m] = sel;
        m_valid[m] = 1;
      end else if (accept) begin
        m_valid[m] = 0;
      end
      if (en) m_pend[m] = m_pend[m] | evt;
      m_ovf[m] = (m_ovf[m] && !ovf_clr) || ovf_new;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    if (!rst) model_step();
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    req = 8'h00; en = 1'b1; ready = 1'b0; ovf_clr = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    for (int t = 0; t < 20; t++) begin
      tick();
      for (int m = 0; m < 2; m++) begin
        checks++;
        if (dut_vec(m) !== 21'd0 || exp_vec(m) !== 21'd0) begin
          errors++;
          $display("FAIL reset_idle inst=%0d got=%h exp=%h", m, dut_vec(m), 21'd0);
        end
      end
    end
  endtask

  task automatic test_latency();
    int first, vcount;
    do_reset();
    ready = 1'b1; req = 8'h20;
    first = -1; vcount = 0;
    for (int t = 1; t <= 10; t++) begin
      tick();
      if (valid_r) begin
        vcount++;
        if (first < 0) first = t;
      end
      for (int m = 0; m < 2; m++) begin
        checks++;
        if (dut_vec(m) !== exp_vec(m)) begin
          errors++;
          $display("FAIL latency_model inst=%0d got=%h exp=%h", m, dut_vec(m), exp_vec(m));
        end
      end
    end
    checks++;
    if (first != 4 || vcount != 1 || code_r !== 3'd5 || cnt_r !== 8'd1) begin
      errors++;
      $display("FAIL latency first=%0d vcycles=%0d code=%0d cnt=%0d exp first=4 vcycles=1 code=5 cnt=1",
               first, vcount, code_r, cnt_r);
    end
    req = 8'h00;
  endtask

  task automatic test_round_robin();
    int n;
    do_reset();
    for (int rep = 0; rep < 2; rep++) begin
      ready = 1'b0; req = 8'h81;
      tick();
      req = 8'h00;
      n = 0;
      while (!valid_r && n < 10) begin
        tick();
        n++;
        for (int m = 0; m < 2; m++) begin
          checks++;
          if (dut_vec(m) !== exp_vec(m)) begin
            errors++;
            $display("FAIL rr_model inst=%0d got=%h exp=%h", m, dut_vec(m), exp_vec(m));
          end
        end
      end
      checks++;
      if (valid_r !== 1'b1 || code_r !== 3'd0 || code_f !== 3'd0) begin
        errors++;
        $display("FAIL rr_first rep=%0d valid=%b code_rr=%0d code_fix=%0d exp valid=1 code 0/0",
                 rep, valid_r, code_r, code_f);
      end
      ready = 1'b1;
      tick();
      checks++;
      if (valid_r !== 1'b1 || code_r !== 3'd7 || code_f !== 3'd7) begin
        errors++;
        $display("FAIL rr_second rep=%0d valid=%b code_rr=%0d code_fix=%0d exp valid=1 code 7/7",
                 rep, valid_r, code_r, code_f);
      end
      tick();
      checks++;
      if (valid_r !== 1'b0 || valid_f !== 1'b0) begin
        errors++;
        $display("FAIL rr_drain rep=%0d valid_rr=%b valid_fix=%b exp 0/0", rep, valid_r, valid_f);
      end
    end
  endtask

  task automatic test_back_to_back();
    int n;
    logic [2:0] exp_code;
    do_reset();
    ready = 1'b1; req = 8'h0E;
    tick();
    req = 8'h00;
    n = 0;
    while (!valid_r && n < 10) begin
      tick();
      n++;
    end
    for (int i = 1; i <= 3; i++) begin
      exp_code = 3'(i);
      checks++;
      if (valid_r !== 1'b1 || code_r !== exp_code) begin
        errors++;
        $display("FAIL b2b_code step=%0d valid=%b code=%0d exp valid=1 code=%0d", i, valid_r, code_r, exp_code);
      end
      for (int m = 0; m < 2; m++) begin
        checks++;
        if (dut_vec(m) !== exp_vec(m)) begin
          errors++;
          $display("FAIL b2b_model inst=%0d got=%h exp=%h", m, dut_vec(m), exp_vec(m));
        end
      end
      tick();
    end
    checks++;
    if (valid_r !== 1'b0 || cnt_r !== 8'd3 || cnt_f !== 8'd3) begin
      errors++;
      $display("FAIL b2b_end valid=%b cnt_rr=%0d cnt_fix=%0d exp valid=0 cnt=3", valid_r, cnt_r, cnt_f);
    end
  endtask

  task automatic test_overflow();
    logic [7:0] seq [6];
    seq = '{8'h04, 8'h00, 8'h04, 8'h00, 8'h00, 8'h00};
    do_reset();
    ready = 1'b0;
    for (int i = 0; i < 6; i++) begin
      req = seq[i];
      tick();
      for (int m = 0; m < 2; m++) begin
        checks++;
        if (dut_vec(m) !== exp_vec(m)) begin
          errors++;
          $display("FAIL ovf_model inst=%0d got=%h exp=%h", m, dut_vec(m), exp_vec(m));
        end
      end
    end
    checks++;
    if (ovf_r !== 1'b1 || pend_r[2] !== 1'b1 || code_r !== 3'd2 || valid_r !== 1'b1) begin
      errors++;
      $display("FAIL ovf_set ovf=%b pend2=%b code=%0d valid=%b exp 1 1 2 1", ovf_r, pend_r[2], code_r, valid_r);
    end
    ovf_clr = 1'b1;
    tick();
    ovf_clr = 1'b0;
    checks++;
    if (ovf_r !== 1'b0 || ovf_f !== 1'b0) begin
      errors++;
      $display("FAIL ovf_clear ovf_rr=%b ovf_fix=%b exp 0/0", ovf_r, ovf_f);
    end
    // lane 2 event lands on the edge that accepts and re-grants lane 2
    req = 8'h04;
    tick();
    req = 8'h00;
    tick();
    ready = 1'b1;
    tick();
    ready = 1'b0;
    checks++;
    if (pend_r[2] !== 1'b1 || ovf_r !== 1'b0 || valid_r !== 1'b1 || code_r !== 3'd2) begin
      errors++;
      $display("FAIL ovf_coincide pend2=%b ovf=%b valid=%b code=%0d exp 1 0 1 2", pend_r[2], ovf_r, valid_r, code_r);
    end
    for (int m = 0; m < 2; m++) begin
      checks++;
      if (dut_vec(m) !== exp_vec(m)) begin
        errors++;
        $display("FAIL ovf_coincide_model inst=%0d got=%h exp=%h", m, dut_vec(m), exp_vec(m));
      end
    end
  endtask

  task automatic test_en_gating();
    logic [7:0] pend_before;
    pend_before = pend_r;
    en = 1'b0; ready = 1'b0;
    for (int i = 0; i < 9; i++) begin
      req = (i < 6 && (i % 2) == 0) ? 8'hFF : 8'h00;
      tick();
      for (int m = 0; m < 2; m++) begin
        checks++;
        if (dut_vec(m) !== exp_vec(m)) begin
          errors++;
          $display("FAIL en_model inst=%0d got=%h exp=%h", m, dut_vec(m), exp_vec(m));
        end
      end
    end
    checks++;
    if (pend_r !== pend_before || ovf_r !== 1'b0 || valid_r !== 1'b1) begin
      errors++;
      $display("FAIL en_hold pend=%h ovf=%b valid=%b exp pend=%h ovf=0 valid=1", pend_r, ovf_r, valid_r, pend_before);
    end
    ready = 1'b1;
    tick();
    ready = 1'b0;
    checks++;
    if (valid_r !== 1'b0 || pend_r !== pend_before) begin
      errors++;
      $display("FAIL en_no_grant valid=%b pend=%h exp valid=0 pend=%h", valid_r, pend_r, pend_before);
    end
    en = 1'b1;
    tick();
    for (int m = 0; m < 2; m++) begin
      checks++;
      if (dut_vec(m) !== exp_vec(m)) begin
        errors++;
        $display("FAIL en_resume inst=%0d got=%h exp=%h", m, dut_vec(m), exp_vec(m));
      end
    end
  endtask

  task automatic test_reset_mid_op();
    int n;
    bit seen4;
    req = 8'h10; ready = 1'b0;
    repeat (3) tick();
    checks++;
    if (valid_r !== 1'b1) begin
      errors++;
      $display("FAIL midrst_pre valid=%b exp 1", valid_r);
    end
    rst = 1'b1;
    model_reset();
    #1;
    for (int m = 0; m < 2; m++) begin
      checks++;
      if (dut_vec(m) !== 21'd0) begin
        errors++;
        $display("FAIL midrst_async inst=%0d got=%h exp=%h", m, dut_vec(m), 21'd0);
      end
    end
    @(posedge clk);
    #1 rst = 1'b0;
    ready = 1'b1;
    seen4 = 0;
    n = 0;
    while (!seen4 && n < 12) begin
      tick();
      n++;
      if (valid_r === 1'b1 && code_r === 3'd4) seen4 = 1;
      for (int m = 0; m < 2; m++) begin
        checks++;
        if (dut_vec(m) !== exp_vec(m)) begin
          errors++;
          $display("FAIL midrst_model inst=%0d got=%h exp=%h", m, dut_vec(m), exp_vec(m));
        end
      end
    end
    checks++;
    if (!seen4) begin
      errors++;
      $display("FAIL midrst_fresh_event grant_seen=0 exp grant of lane 4");
    end
    req = 8'h00;
  endtask

  task automatic test_random();
    do_reset();
    for (int t = 0; t < 800; t++) begin
      req     = 8'($urandom) & 8'($urandom) & 8'($urandom);
      en      = ($urandom_range(0, 7) != 0);
      ready   = $urandom_range(0, 1) == 1;
      ovf_clr = ($urandom_range(0, 15) == 0);
      tick();
      for (int m = 0; m < 2; m++) begin
        checks++;
        if (dut_vec(m) !== exp_vec(m)) begin
          errors++;
          $display("FAIL random t=%0d inst=%0d got=%h exp=%h", t, m, dut_vec(m), exp_vec(m));
        end
      end
    end
  endtask

  initial begin
    clk = 1'b0; rst = 1'b1; en = 1'b0; req = 8'h00; ready = 1'b0; ovf_clr = 1'b0;
    checks = 0; errors = 0;
    model_reset();
    test_reset();
    test_latency();
    test_round_robin();
    test_back_to_back();
    test_overflow();
    test_en_gating();
    test_reset_mid_op();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
